tv_vram_arbiter: RTL and testbench
==================================

// Module: tv_vram_arbiter
// PURPOSE
// - Shares one single-port synchronous video RAM between TV-out scanout and a host (CPU/loader) port.
// - Scanout has strict priority. A one-word prefetch buffer plus a 16-bit shifter turn RAM words into a 1-bit pixel stream.
// - Sits between the PAL timing generator (pix_en / active / frame_start) and the composite output stage.
// PARAMETERS
// - AW     14    RAM word-address width
// - DW     16    RAM word width; pixels per word; MSB is shown first
// - WORDS  9184  scanout words per frame (512 x 287 / 16); scanout address wraps after WORDS-1
// PORTS
// - clk          in   1   system clock (50 MHz)
// - rst          in   1   synchronous, active-high reset
// - pix_en       in   1   pixel strobe, one clk in every 5
// - active       in   1   visible-pixel flag; sampled only when pix_en=1
// - frame_start  in   1   one-clk pulse during vertical blanking
// - pixel        out  1   registered pixel bit
// - host_valid   in   1   host request
// - host_we      in   1   1 = write, 0 = read
// - host_addr    in   AW  host word address
// - host_wdata   in   DW  host write data
// - host_ready   out  1   transfer occurs when host_valid && host_ready
// - host_rvalid  out  1   one-clk pulse carrying read data
// - host_rdata   out  DW  read data; valid only when host_rvalid=1
// - ram_addr     out  AW  RAM address (combinational from grant)
// - ram_we       out  1   RAM write enable
// - ram_wdata    out  DW  RAM write data
// - ram_rdata    in   DW  RAM read data, one clk after address
// BEHAVIOUR
// - Reset: pixel=0, host_rvalid=0, ram_we=0, vaddr=0, bitcnt=0, buf_full=0, inflight=0, shreg=0.
// - vid_req = !buf_full && !inflight. host_ready = !vid_req. host_ready never depends on host_valid.
// - vid_req=1 cycle: ram_addr=vaddr, ram_we=0; inflight<=1; vaddr<=(vaddr==WORDS-1)?0:vaddr+1.
// - Next cycle: buf<=ram_rdata, buf_full<=1, inflight<=0.
// - Host handshake cycle: ram_addr=host_addr, ram_we=host_we, ram_wdata=host_wdata.
// - Host read: host_rvalid=1 with host_rdata=ram_rdata exactly 1 clk after the handshake. No outstanding limit.
// - Idle cycle (no vid_req, no host_valid): ram_we=0; ram_addr is don't-care.
// - pix_en && active, bitcnt==0:
//   - buf_full=1: pixel<=buf[DW-1], shreg<=buf<<1, buf_full<=0.
//   - buf_full=0 (underrun): pixel<=0, shreg<=0.
// - pix_en && active, bitcnt!=0: pixel<=shreg[DW-1], shreg<=shreg<<1.
// - In both active cases bitcnt<=bitcnt+1 (mod DW).
// - pix_en && !active: pixel<=0; bitcnt and shreg hold (512 is a multiple of DW, so lines end aligned).
// - Pixel latency: pixel updates on the pix_en cycle and reflects that cycle's active flag.
// - frame_start: vaddr<=0, bitcnt<=0, buf_full<=0, shreg<=0.
//   - If a read is in flight, its returning data is discarded (buf_full stays 0).
//   - frame_start overrides a coincident pix_en update; pixel<=0.
// - Buffer load and shifter unload in the same cycle: the load wins and buf_full<=1.
// - Scanout deadline: at most 2 clk to refill per 80 clk word time, so underrun happens only right after frame_start.
// CONFIGURATION
// - TVOUT_UNDERRUN_CNT_EN defined: adds output underrun_cnt [15:0].
//   - Increments, saturating, on each underrun event; reset to 0 by rst only.
// - Macro undefined: no port and no counter; underrun behaviour of pixel is unchanged.
// STRUCTURE
// - tvout_pkg: TV_H_ACTIVE=512, TV_V_ACTIVE=287, VRAM_DW=16, VRAM_AW=14, VRAM_WORDS=9184.
// - Sub-module tv_pixel_shifter: buf, buf_full, shreg, bitcnt, pixel.
//   - Interface: load/ldata in, need (buf empty) out.
// - Arbiter, vaddr and host logic stay in the top.
// TESTING
// - RAM[0]=16'hA5A5, RAM[1]=16'hFFFF; frame_start, then 32 active pix_en
//   -> pixel = 1010_0101_1010_0101 then sixteen 1s; no underrun.
// - host_valid=1 writes held through scanout
//   -> host_ready=0 only on the cycles vid reads issue; all writes read back correctly.
// - Host read addr 14'h0010 holding 16'h1234 -> host_rvalid=1 one clk after handshake, host_rdata=16'h1234.
// - vaddr=WORDS-1 fetch -> following fetch ram_addr=0.
// - frame_start on the cycle after a vid read issues
//   -> that data is discarded; next ram_addr=0; first pixel comes from RAM[0].
// - frame_start, then active pix_en 1 clk later
//   -> pixel=0; underrun_cnt=1 with TVOUT_UNDERRUN_CNT_EN defined.

Source files
------------

// File: rtl/tvout_pkg.sv
// Shared constants and types for the TV-out video path.
package tvout_pkg;

  localparam int TV_H_ACTIVE = 512;
  localparam int TV_V_ACTIVE = 287;
  localparam int VRAM_DW     = 16;
  localparam int VRAM_AW     = 14;
  localparam int VRAM_WORDS  = TV_H_ACTIVE * TV_V_ACTIVE / VRAM_DW;

  // Owner of the RAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_HOST = 2'd2
  } grant_t;

endpackage

// File: rtl/tv_pixel_shifter.sv
// One-word prefetch buffer and 16-bit shifter producing the 1-bit pixel stream.
// Optional feature macro: TVOUT_UNDERRUN_CNT_EN adds a saturating underrun counter.
module tv_pixel_shifter
  import tvout_pkg::*;
#(
  parameter int DW = VRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          active,
  input  logic          frame_start,
  input  logic          load,
  input  logic [DW-1:0] ldata,
  output logic          need,
  output logic          pixel
`ifdef TVOUT_UNDERRUN_CNT_EN
  ,
  output logic [15:0]   underrun_cnt
`endif
);

  localparam int BW = $clog2(DW);

  logic [DW-1:0] buf_q;
  logic          buf_full;
  logic [DW-1:0] shreg;
  logic [BW-1:0] bitcnt;

  assign need = !buf_full;

  // Buffer load, word hand-over to the shifter and pixel output; a load beats an unload.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      pixel    <= 1'b0;
    end else if (frame_start) begin
      buf_full <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      pixel    <= 1'b0;
    end else begin
      if (pix_en) begin
        if (active) begin
          if (bitcnt == '0) begin
            if (buf_full) begin
              pixel    <= buf_q[DW-1];
              shreg    <= buf_q << 1;
              buf_full <= 1'b0;
            end else begin
              pixel <= 1'b0;
              shreg <= '0;
            end
          end else begin
            pixel <= shreg[DW-1];
            shreg <= shreg << 1;
          end
          bitcnt <= (bitcnt == BW'(DW-1)) ? '0 : bitcnt + 1'b1;
        end else begin
          pixel <= 1'b0;
        end
      end
      if (load) begin
        buf_q    <= ldata;
        buf_full <= 1'b1;
      end
    end
  end

`ifdef TVOUT_UNDERRUN_CNT_EN
  logic underrun;

  assign underrun = pix_en && active && (bitcnt == '0) && !buf_full && !frame_start;

  // Saturating count of word starts that found the buffer empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/tv_vram_arbiter.sv
// Single-port VRAM arbiter: scanout prefetch has strict priority over the host port.
// Optional feature macro: TVOUT_UNDERRUN_CNT_EN adds output underrun_cnt.
module tv_vram_arbiter
  import tvout_pkg::*;
#(
  parameter int AW    = VRAM_AW,
  parameter int DW    = VRAM_DW,
  parameter int WORDS = VRAM_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          active,
  input  logic          frame_start,
  output logic          pixel,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef TVOUT_UNDERRUN_CNT_EN
  ,
  output logic [15:0]   underrun_cnt
`endif
);

  logic [AW-1:0] vaddr;
  logic          inflight;
  logic          need;
  logic          vid_req;
  grant_t        grant;

  assign vid_req    = need && !inflight;
  assign host_ready = !vid_req;
  assign host_rdata = ram_rdata;

  // Grant: scanout first, host only when scanout does not need the port.
  always_comb begin
    grant = GNT_IDLE;
    if (vid_req) begin
      grant = GNT_VID;
    end else if (host_valid) begin
      grant = GNT_HOST;
    end
  end

  // RAM port mux driven straight from the grant.
  always_comb begin
    ram_addr  = host_addr;
    ram_we    = 1'b0;
    ram_wdata = host_wdata;
    case (grant)
      GNT_VID:  ram_addr = vaddr;
      GNT_HOST: ram_we   = host_we;
      default:  ;
    endcase
  end

  // Scanout address, in-flight marker and host read-return strobe.
  // Clearing inflight on frame_start makes the returning word miss the buffer load.
  always_ff @(posedge clk) begin
    if (rst) begin
      vaddr       <= '0;
      inflight    <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      inflight    <= vid_req && !frame_start;
      host_rvalid <= (grant == GNT_HOST) && !host_we;
      if (frame_start) begin
        vaddr <= '0;
      end else if (vid_req) begin
        vaddr <= (vaddr == AW'(WORDS-1)) ? '0 : vaddr + 1'b1;
      end
    end
  end

  tv_pixel_shifter #(.DW(DW)) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .active      (active),
    .frame_start (frame_start),
    .load        (inflight),
    .ldata       (ram_rdata),
    .need        (need),
    .pixel       (pixel)
`ifdef TVOUT_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

endmodule

// File: tb/tb_tv_vram_arbiter.sv
// Bench for tv_vram_arbiter: RAM model, pixel/host/scanout scoreboards, table-driven host traffic.
module tb_tv_vram_arbiter;

  localparam int TB_WORDS = 6;

  logic        clk = 1'b0;
  logic        rst, pix_en, active, frame_start;
  logic        pixel;
  logic        host_valid, host_we, host_ready, host_rvalid;
  logic [13:0] host_addr, ram_addr;
  logic [15:0] host_wdata, host_rdata, ram_wdata, ram_rdata;
  logic        ram_we;
`ifdef TVOUT_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  tv_vram_arbiter #(.WORDS(TB_WORDS)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .active(active), .frame_start(frame_start),
    .pixel(pixel), .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef TVOUT_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  // Synchronous single-port RAM (read-first) with a bench preload path.
  logic [15:0] mem [0:16383];
  logic        pl_we;
  logic [13:0] pl_addr;
  logic [15:0] pl_data;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards
  bit          px_q [$];
  logic [15:0] rq [$];
  logic        px_pend = 1'b0;
  logic        rd_pend = 1'b0;
  int          exp_vaddr = 0;
  int          fetches = 0;

  always @(posedge clk) begin
    px_pend <= pix_en && !rst;
    rd_pend <= !rst && host_valid && host_ready && !host_we;
  end

  // Pixel scoreboard: one expected bit per pix_en cycle.
  always @(negedge clk) begin
    if (px_pend) begin
      if (px_q.size() == 0) chk(1'b0, "pixel_sb_empty", 32'(pixel), 32'h0);
      else begin
        chk(pixel == px_q[0], "pixel", 32'(pixel), 32'(px_q[0]));
        void'(px_q.pop_front());
      end
    end
  end

  // Host read-return scoreboard.
  always @(negedge clk) begin
    if (!rst && (rd_pend || host_rvalid)) begin
      chk(host_rvalid == rd_pend, "host_rvalid", 32'(host_rvalid), 32'(rd_pend));
      if (rd_pend && rq.size() > 0) begin
        chk(host_rdata == rq[0], "host_rdata", 32'(host_rdata), 32'(rq[0]));
        void'(rq.pop_front());
      end
    end
  end

  // Scanout address sequence and RAM-port routing.
  always @(negedge clk) begin
    if (rst) begin
      exp_vaddr <= 0;
      fetches   <= 0;
    end else begin
      if (!host_ready) begin
        chk(ram_addr == 14'(exp_vaddr), "vid_ram_addr", 32'(ram_addr), 32'(exp_vaddr));
        chk(ram_we == 1'b0, "vid_ram_we", 32'(ram_we), 32'h0);
        exp_vaddr <= (exp_vaddr == TB_WORDS-1) ? 0 : exp_vaddr + 1;
        fetches   <= fetches + 1;
      end else if (host_valid) begin
        chk(ram_addr == host_addr, "host_ram_addr", 32'(ram_addr), 32'(host_addr));
        chk(ram_we == host_we, "host_ram_we", 32'(ram_we), 32'(host_we));
        if (host_we) chk(ram_wdata == host_wdata, "host_ram_wdata", 32'(ram_wdata), 32'(host_wdata));
      end
      if (frame_start) begin
        exp_vaddr <= 0;
        fetches   <= 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit          we;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } host_rec_t;

  host_rec_t   host_tab [9];
  logic [15:0] vid_words [6];
  logic [15:0] w0, w1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pix(input bit act, input bit exp);
    pix_en = 1'b1;
    active = act;
    px_q.push_back(exp);
    step();
    pix_en = 1'b0;
    active = 1'b0;
  endtask

  task automatic host_xfer(input host_rec_t r);
    bit done;
    done       = 1'b0;
    host_valid = 1'b1;
    host_we    = r.we;
    host_addr  = r.addr;
    host_wdata = r.wdata;
    for (int k = 0; k < 50 && !done; k++) begin
      if (host_ready) begin
        if (!r.we) rq.push_back(r.exp_rdata);
        done = 1'b1;
      end
      step();
    end
    if (!done) chk(1'b0, "host_ready_timeout", 32'(r.addr), 32'h1);
  endtask

  initial begin
    host_tab[0] = '{1'b1, 14'h0100, 16'hBEEF, 16'h0000};
    host_tab[1] = '{1'b1, 14'h0101, 16'h1357, 16'h0000};
    host_tab[2] = '{1'b1, 14'h3FFF, 16'hC0DE, 16'h0000};
    host_tab[3] = '{1'b0, 14'h0010, 16'h0000, 16'h1234};
    host_tab[4] = '{1'b0, 14'h0100, 16'h0000, 16'hBEEF};
    host_tab[5] = '{1'b0, 14'h0101, 16'h0000, 16'h1357};
    host_tab[6] = '{1'b0, 14'h3FFF, 16'h0000, 16'hC0DE};
    host_tab[7] = '{1'b1, 14'h0100, 16'h0F0F, 16'h0000};
    host_tab[8] = '{1'b0, 14'h0100, 16'h0000, 16'h0F0F};
    vid_words[0] = 16'hA5A5; vid_words[1] = 16'hFFFF; vid_words[2] = 16'h0F0F;
    vid_words[3] = 16'h8001; vid_words[4] = 16'h3C3C; vid_words[5] = 16'hC35A;
    w0 = 16'hA5A5;
    w1 = 16'hFFFF;

    rst = 1'b1; pix_en = 1'b0; active = 1'b0; frame_start = 1'b0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      pl_we = 1'b1; pl_addr = 14'(i); pl_data = vid_words[i];
      step();
    end
    pl_addr = 14'h0010; pl_data = 16'h1234;
    step();
    pl_we = 1'b0;
    step();

    // Reset state
    chk(pixel == 1'b0, "rst_pixel", 32'(pixel), 32'h0);
    chk(host_rvalid == 1'b0, "rst_host_rvalid", 32'(host_rvalid), 32'h0);
    chk(ram_we == 1'b0, "rst_ram_we", 32'(ram_we), 32'h0);
    chk(host_ready == 1'b0, "rst_host_ready", 32'(host_ready), 32'h0);
    chk(ram_addr == 14'h0, "rst_ram_addr", 32'(ram_addr), 32'h0);
    rst = 1'b0;
    step();

    // Basic scanout of A5A5 then FFFF, with one blanked pulse mid-word
    frame_start = 1'b1; step(); frame_start = 1'b0;
    idle(4);
    for (int i = 0; i < 32; i++) begin
      if (i == 8) begin
        pix(1'b0, 1'b0);
        idle(4);
      end
      pix(1'b1, (i < 16) ? w0[15-i] : w1[31-i]);
      idle(4);
    end
`ifdef TVOUT_UNDERRUN_CNT_EN
    chk(underrun_cnt == 16'd0, "underrun_cnt_none", 32'(underrun_cnt), 32'h0);
`endif

    // Host traffic held through fast scanout, including address wrap
    frame_start = 1'b1; step(); frame_start = 1'b0;
    idle(4);
    fork
      begin
        for (int n = 0; n < 128; n++) pix(1'b1, vid_words[(n/16)%6][15-(n%16)]);
      end
      begin
        for (int t = 0; t < 9; t++) host_xfer(host_tab[t]);
        host_valid = 1'b0;
      end
    join
    idle(4);
    chk(fetches == 9, "vid_fetch_count", 32'(fetches), 32'd9);

    // frame_start on the cycle after a vid read issues: returning word is dropped
    frame_start = 1'b1; step(); frame_start = 1'b0;
    idle(4);
    pix(1'b1, w0[15]);
    chk(host_ready == 1'b0, "refill_issue", 32'(host_ready), 32'h0);
    step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    idle(4);
    for (int i = 0; i < 16; i++) begin
      pix(1'b1, w0[15-i]);
      idle(4);
    end

    // frame_start coincident with pix_en: pixel forced low, no underrun
    frame_start = 1'b1;
    pix(1'b1, 1'b0);
    frame_start = 1'b0;
`ifdef TVOUT_UNDERRUN_CNT_EN
    chk(underrun_cnt == 16'd0, "underrun_cnt_fs_override", 32'(underrun_cnt), 32'h0);
`endif
    idle(4);
    pix(1'b1, 1'b1);
    idle(4);

    // Active pixel one clk after frame_start: underrun
    frame_start = 1'b1; step(); frame_start = 1'b0;
    pix(1'b1, 1'b0);
`ifdef TVOUT_UNDERRUN_CNT_EN
    chk(underrun_cnt == 16'd1, "underrun_cnt_one", 32'(underrun_cnt), 32'h1);
`endif
    idle(6);

    chk(px_q.size() == 0, "pixel_sb_leftover", 32'(px_q.size()), 32'h0);
    chk(rq.size() == 0, "host_rd_sb_leftover", 32'(rq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
